naval_game_fsm: RTL
===================

NAVAL_GAME_FSM -- requirements
Module: naval_game_fsm

Interface
REQ-001 SHALL have parameter SHIP_COUNT, 3, ships per side (legal 1..15).
REQ-002 SHALL have parameter TURN_TIMEOUT, 16, player-turn cycle limit (legal >=2).
REQ-003 SHALL derive CNT_W = $clog2(SHIP_COUNT+1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 accionador  in  1  start / place-ship / restart button, level sampled each cycle.
REQ-007 disparo  in  1  player shot valid.
REQ-008 acierto  in  1  player shot hit, qualified by disparo.
REQ-009 pc_disparo  in  1  PC shot valid.
REQ-010 pc_acierto  in  1  PC shot hit, qualified by pc_disparo.
REQ-011 state_actual  out  4  current state encoding.
REQ-012 gana / pierde  out  1 each  player won / lost.
REQ-013 turno_jugador  out  1  high in TURNO_JUGADOR.
REQ-014 timeout  out  1  one-cycle pulse on player-turn expiry.
REQ-015 barcos_jugador / barcos_pc  out  CNT_W each  ships remaining per side.

Function
REQ-016 States SHALL be IDLE=0, COLOCACION=1, TURNO_JUGADOR=2, EVAL_JUGADOR=3, TURNO_PC=4, EVAL_PC=5, GANA=6, PIERDE=7; codes 8-15 SHALL go to IDLE next cycle.
REQ-017 IDLE: accionador=1 -> COLOCACION; barcos_jugador<=0, barcos_pc<=SHIP_COUNT at that edge.
REQ-018 COLOCACION: each cycle with accionador=1 SHALL increment barcos_jugador; on the edge making it SHIP_COUNT -> TURNO_JUGADOR.
REQ-019 TURNO_JUGADOR: disparo=1 -> EVAL_JUGADOR, acierto latched into hit_q; disparo SHALL win over simultaneous timeout.
REQ-020 Turn timer SHALL clear on entry to TURNO_JUGADOR, increment each cycle there; at value TURN_TIMEOUT-1 with disparo=0 -> TURNO_PC and timeout=1 for that cycle.
REQ-021 EVAL_JUGADOR (1 cycle): hit_q && barcos_pc==1 -> GANA; hit_q -> TURNO_JUGADOR (extra shot); else TURNO_PC; on hit barcos_pc SHALL decrement, saturating at 0.
REQ-022 TURNO_PC: pc_disparo=1 -> EVAL_PC with pc_acierto latched; no timeout.
REQ-023 EVAL_PC mirrors REQ-021 on barcos_jugador: final hit -> PIERDE; hit -> TURNO_PC; miss -> TURNO_JUGADOR.
REQ-024 gana=1 exactly while in GANA, pierde=1 exactly while in PIERDE; never both.
REQ-025 GANA/PIERDE SHALL hold until accionador=1 -> IDLE, counters unchanged until next start.
REQ-026 accionador SHALL be ignored in states 2-5; disparo/pc_disparo SHALL be ignored outside their TURNO state.
REQ-027 Outputs SHALL be registered or decoded from registered state only; no combinational input-to-output path.

Reset
REQ-028 reset=1 at any edge, including mid-game, SHALL force IDLE, state_actual=0, gana=0, pierde=0, turno_jugador=0, timeout=0, timer=0, hit_q=0, barcos_jugador=0, barcos_pc=0.
REQ-029 reset SHALL take priority over every other input.

Configuration
REQ-030 With FSM_TIMEOUT_EN defined, turn timer and timeout behave per REQ-020.
REQ-031 Without FSM_TIMEOUT_EN, timer logic SHALL be absent, timeout tied 0, TURNO_JUGADOR waits indefinitely for disparo.

Verification (SHIP_COUNT=2, TURN_TIMEOUT=4, FSM_TIMEOUT_EN defined)
REQ-032 reset 2 cycles, accionador=1 for 3 cycles -> state 0,1,1,2; barcos_jugador=2, barcos_pc=2.
REQ-033 In TURNO_JUGADOR, disparo=1 acierto=1 twice -> EVAL_JUGADOR, TURNO_JUGADOR, EVAL_JUGADOR, GANA; barcos_pc 2->1->0; gana=1, pierde=0.
REQ-034 In TURNO_JUGADOR, idle 4 cycles -> timeout=1 on 4th cycle, state 4 next; disparo=1 on that same cycle -> state 3, timeout=0.
REQ-035 Player misses, pc_disparo=1 pc_acierto=1 twice -> PIERDE, barcos_jugador=0, pierde=1; accionador=1 -> IDLE.
REQ-036 reset=1 during EVAL_PC -> next cycle state 0, all outputs 0; build without FSM_TIMEOUT_EN: 20 idle cycles in state 2 -> stays 2, timeout=0.

Source files
------------

// File: rtl/naval_game_fsm.sv
// Two-sided naval battle game controller: placement, alternating turns, win/loss.
// Optional player-turn timer enabled by defining FSM_TIMEOUT_EN.
module naval_game_fsm #(
  parameter int SHIP_COUNT   = 3,
  parameter int TURN_TIMEOUT = 16,
  localparam int CNT_W       = $clog2(SHIP_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accionador,
  input  logic             disparo,
  input  logic             acierto,
  input  logic             pc_disparo,
  input  logic             pc_acierto,
  output logic [3:0]       state_actual,
  output logic             gana,
  output logic             pierde,
  output logic             turno_jugador,
  output logic             timeout,
  output logic [CNT_W-1:0] barcos_jugador,
  output logic [CNT_W-1:0] barcos_pc
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_COLOC  = 4'd1;
  localparam logic [3:0] S_TURNO  = 4'd2;
  localparam logic [3:0] S_EVAL   = 4'd3;
  localparam logic [3:0] S_TPC    = 4'd4;
  localparam logic [3:0] S_EPC    = 4'd5;
  localparam logic [3:0] S_GANA   = 4'd6;
  localparam logic [3:0] S_PIERDE = 4'd7;

  if (SHIP_COUNT < 1 || SHIP_COUNT > 15 || TURN_TIMEOUT < 2)
  begin : g_bad_param
    $error("naval_game_fsm: illegal parameter value");
  end

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] bj_q, bj_d;
  logic [CNT_W-1:0] bp_q, bp_d;
  logic             hit_q, hit_d;
  logic             expire;

`ifdef FSM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TURN_TIMEOUT);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;

  assign expire = (timer_q == TMR_W'(TURN_TIMEOUT - 1));

  // Timer restarts whenever the player's turn is (re)entered.
  always_comb begin
    timer_d   = '0;
    timeout_d = 1'b0;
    if (state_q == S_TURNO && state_d == S_TURNO)
      timer_d = timer_q + 1'b1;
    if (state_q == S_TURNO && !disparo && expire)
      timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bj_d    = bj_q;
    bp_d    = bp_q;
    hit_d   = hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (accionador) begin
          state_d = S_COLOC;
          bj_d    = '0;
          bp_d    = CNT_W'(SHIP_COUNT);
        end
      end
      S_COLOC: begin
        if (accionador) begin
          bj_d = bj_q + 1'b1;
          if (bj_q == CNT_W'(SHIP_COUNT - 1))
            state_d = S_TURNO;
        end
      end
      S_TURNO: begin
        if (disparo) begin
          hit_d   = acierto;
          state_d = S_EVAL;
        end else if (expire) begin
          state_d = S_TPC;
        end
      end
      S_EVAL: begin
        if (hit_q && bp_q != '0)
          bp_d = bp_q - 1'b1;
        if (hit_q && bp_q == CNT_W'(1))
          state_d = S_GANA;
        else if (hit_q)
          state_d = S_TURNO;
        else
          state_d = S_TPC;
      end
      S_TPC: begin
        if (pc_disparo) begin
          hit_d   = pc_acierto;
          state_d = S_EPC;
        end
      end
      S_EPC: begin
        if (hit_q && bj_q != '0)
          bj_d = bj_q - 1'b1;
        if (hit_q && bj_q == CNT_W'(1))
          state_d = S_PIERDE;
        else if (hit_q)
          state_d = S_TPC;
        else
          state_d = S_TURNO;
      end
      S_GANA, S_PIERDE: begin
        if (accionador)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bj_q    <= '0;
      bp_q    <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bj_q    <= bj_d;
      bp_q    <= bp_d;
      hit_q   <= hit_d;
    end
  end

  assign state_actual   = state_q;
  assign gana           = (state_q == S_GANA);
  assign pierde         = (state_q == S_PIERDE);
  assign turno_jugador  = (state_q == S_TURNO);
  assign barcos_jugador = bj_q;
  assign barcos_pc      = bp_q;

endmodule
